scr_base_l3_bk_tp_twr: RTL and testbench

- L3 bank tag pipe tag-write buffer. This is the writer side of the tag RAM, which the tag pipe D1 stage reads.
- Accepts tag/state updates from late tag-pipe stages and queues them in order.
- Drains them into the single-port tag RAM in cycles when D1 is not reading.
- Bounds write starvation and flags D1 lookups that hit a set with a pending write.

---
 rtl/scr_base_l3_bk_pkg.sv | 31 +++
 rtl/scr_base_l3_bk_tp_twr_fifo.sv | 59 +++++
 rtl/scr_base_l3_bk_tp_twr.sv | 94 +++++++++
 tb/tb_scr_base_l3_bk_tp_twr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_base_l3_bk_pkg.sv
// Shared types and constants for the L3 bank tag pipe tag-write buffer.
package scr_base_l3_bk_pkg;

    localparam int SET_W      = 10;
    localparam int WAY_N      = 16;
    localparam int WAY_W      = $clog2(WAY_N);
    localparam int TAG_W      = 24;
    localparam int ST_W       = 3;
    localparam int DEPTH      = 4;
    localparam int CNT_W      = $clog2(DEPTH) + 1;
    localparam int STARVE_MAX = 8;
    localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [SET_W-1:0] set;
        logic [WAY_W-1:0] way;
        logic [TAG_W-1:0] tag;
        logic [ST_W-1:0]  st;
    } tp_twr_entry_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [ST_W-1:0]  st;
    } tp_twr_wdata_t;

    function automatic logic [WAY_N-1:0] way_idx_to_mask(input logic [WAY_W-1:0] way);
        way_idx_to_mask      = '0;
        way_idx_to_mask[way] = 1'b1;
    endfunction

endpackage

// File: rtl/scr_base_l3_bk_tp_twr_fifo.sv
// Circular FIFO of tag-write entries; exposes every slot and its validity so
// the owner can compare against all pending writes.
module scr_base_l3_bk_tp_twr_fifo
    import scr_base_l3_bk_pkg::*;
#(
    parameter int F_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  tp_twr_entry_t               push_data,
    input  logic                        pop,
    output tp_twr_entry_t               head,
    output logic [$clog2(F_DEPTH):0]    cnt,
    output logic [F_DEPTH-1:0]          ent_vld,
    output tp_twr_entry_t               ents [F_DEPTH]
);

    localparam int PTR_W = $clog2(F_DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] off [F_DEPTH];
    tp_twr_entry_t    mem [F_DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is deliberately left unreset; slot validity comes only
    // from the pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < F_DEPTH; i++) begin : g_vld
        assign off[i]     = PTR_W'(i) - rd_ptr;
        assign ent_vld[i] = {1'b0, off[i]} < cnt;
        assign ents[i]    = mem[i];
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/scr_base_l3_bk_tp_twr.sv
// L3 bank tag-write buffer: queues tag/state updates and drains them into the
// single-port tag RAM around D1 reads, forcing a write after bounded starvation.
module scr_base_l3_bk_tp_twr
    import scr_base_l3_bk_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   upd_vld,
    output logic                   upd_rdy,
    input  logic [SET_W-1:0]       upd_set,
    input  logic [WAY_W-1:0]       upd_way,
    input  logic [TAG_W-1:0]       upd_tag,
    input  logic [ST_W-1:0]        upd_st,
    input  logic                   d1_rd_req,
    input  logic [SET_W-1:0]       d1_rd_set,
    output logic                   d1_stall,
    output logic                   d1_haz,
    output logic                   ram_we,
    output logic [SET_W-1:0]       ram_set,
    output logic [WAY_N-1:0]       ram_way_mask,
    output logic [TAG_W+ST_W-1:0]  ram_wdata,
    output logic [CNT_W-1:0]       q_cnt
);

    tp_twr_entry_t        push_data;
    tp_twr_entry_t        head;
    tp_twr_entry_t        ents [DEPTH];
    logic [DEPTH-1:0]     ent_vld;
    logic                 push;
    logic                 head_vld;
    logic                 force_wr;
    logic                 issue;
    logic                 set_match;
    logic [STARVE_W-1:0]  starve_cnt;
    tp_twr_wdata_t        ram_wdata_q;

    assign push_data = '{set: upd_set, way: upd_way, tag: upd_tag, st: upd_st};
    assign upd_rdy   = (q_cnt != CNT_W'(DEPTH));
    assign push      = upd_vld & upd_rdy;

    scr_base_l3_bk_tp_twr_fifo #(.F_DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .head      (head),
        .cnt       (q_cnt),
        .ent_vld   (ent_vld),
        .ents      (ents)
    );

    assign head_vld = (q_cnt != '0);
    assign force_wr = head_vld & (starve_cnt == STARVE_W'(STARVE_MAX));
    assign issue    = head_vld & (~d1_rd_req | force_wr);
    assign d1_stall = force_wr;

    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        set_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ents[i].set == d1_rd_set)) set_match = 1'b1;
        end
    end

    // The in-flight RAM write counts as pending until it has landed.
    assign d1_haz = d1_rd_req & (set_match | (ram_we & (ram_set == d1_rd_set)));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt   <= '0;
            ram_we       <= 1'b0;
            ram_set      <= '0;
            ram_way_mask <= '0;
            ram_wdata_q  <= '0;
        end else begin
            ram_we <= issue;
            if (issue) begin
                ram_set      <= head.set;
                ram_way_mask <= way_idx_to_mask(head.way);
                ram_wdata_q  <= '{tag: head.tag, st: head.st};
            end
            // Saturates because a forced cycle always issues and clears.
            if (issue || !head_vld)
                starve_cnt <= '0;
            else if (d1_rd_req && !force_wr)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_scr_base_l3_bk_tp_twr.sv
// Directed self-checking bench for the L3 bank tag-write buffer.
module tb_scr_base_l3_bk_tp_twr;

    logic        clk;
    logic        rst;
    logic        upd_vld;
    logic        upd_rdy;
    logic [9:0]  upd_set;
    logic [3:0]  upd_way;
    logic [23:0] upd_tag;
    logic [2:0]  upd_st;
    logic        d1_rd_req;
    logic [9:0]  d1_rd_set;
    logic        d1_stall;
    logic        d1_haz;
    logic        ram_we;
    logic [9:0]  ram_set;
    logic [15:0] ram_way_mask;
    logic [26:0] ram_wdata;
    logic [2:0]  q_cnt;

    int vectors;
    int miscompares;

    scr_base_l3_bk_tp_twr dut (
        .clk          (clk),
        .rst          (rst),
        .upd_vld      (upd_vld),
        .upd_rdy      (upd_rdy),
        .upd_set      (upd_set),
        .upd_way      (upd_way),
        .upd_tag      (upd_tag),
        .upd_st       (upd_st),
        .d1_rd_req    (d1_rd_req),
        .d1_rd_set    (d1_rd_set),
        .d1_stall     (d1_stall),
        .d1_haz       (d1_haz),
        .ram_we       (ram_we),
        .ram_set      (ram_set),
        .ram_way_mask (ram_way_mask),
        .ram_wdata    (ram_wdata),
        .q_cnt        (q_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] s, input logic [3:0] w,
                         input logic [23:0] t, input logic [2:0] st);
        upd_vld = 1'b1;
        upd_set = s;
        upd_way = w;
        upd_tag = t;
        upd_st  = st;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        upd_vld     = 1'b0;
        upd_set     = '0;
        upd_way     = '0;
        upd_tag     = '0;
        upd_st      = '0;
        d1_rd_req   = 1'b0;
        d1_rd_set   = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_ram_we",   ram_we,       0);
        check("rst_ram_set",  ram_set,      0);
        check("rst_mask",     ram_way_mask, 0);
        check("rst_wdata",    ram_wdata,    0);
        check("rst_q_cnt",    q_cnt,        0);
        check("rst_upd_rdy",  upd_rdy,      1);
        check("rst_d1_stall", d1_stall,     0);
        check("rst_d1_haz",   d1_haz,       0);

        // Single update, idle reads: write lands two edges after acceptance
        drive(10'h12, 4'd5, 24'hABCDEF, 3'd3);
        #1;
        check("t1_upd_rdy", upd_rdy, 1);
        tick();
        upd_vld = 1'b0;
        #1;
        check("t1_q_cnt_1",   q_cnt,  1);
        check("t1_we_early",  ram_we, 0);
        tick();
        check("t1_ram_we",    ram_we,       1);
        check("t1_ram_set",   ram_set,      32'h12);
        check("t1_mask",      ram_way_mask, 32'h0020);
        check("t1_wdata",     ram_wdata,    32'h55E6F7B);
        check("t1_q_cnt_0",   q_cnt,        0);
        tick();
        check("t1_we_done",   ram_we,       0);

        // Full queue with D1 reading every cycle
        d1_rd_req = 1'b1;
        d1_rd_set = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            drive(10'h100 + 10'(i), 4'(i), 24'h1000 + 24'(i), 3'd1);
            tick();
        end
        drive(10'h104, 4'd4, 24'h1004, 3'd1);
        #1;
        check("t2_full_cnt",  q_cnt,   4);
        check("t2_full_rdy",  upd_rdy, 0);
        repeat (4) tick();
        check("t2_no_stall_8", d1_stall, 0);
        tick();
        check("t2_stall_9",    d1_stall, 1);
        check("t2_no_passthru", upd_rdy, 0);
        check("t2_cnt_at_force", q_cnt,  4);
        tick();
        check("t2_forced_we",  ram_we,   1);
        check("t2_forced_set", ram_set,  32'h100);
        check("t2_cnt_3",      q_cnt,    3);
        check("t2_rdy_again",  upd_rdy,  1);
        check("t2_stall_clr",  d1_stall, 0);
        tick();
        check("t2_fifth_in",   q_cnt,    4);
        upd_vld   = 1'b0;
        d1_rd_req = 1'b0;
        #1;
        check("t2_we_idle",    ram_we,   0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("t2_drain_we",  ram_we,  1);
            check("t2_drain_set", ram_set, 32'h100 + j);
        end
        check("t2_last_mask",  ram_way_mask, 32'h0010);
        check("t2_last_wdata", ram_wdata,    32'h8021);
        tick();
        check("t2_drain_done", ram_we, 0);
        check("t2_empty",      q_cnt,  0);

        // Starvation bound with one entry queued
        d1_rd_req = 1'b1;
        d1_rd_set = 10'h3FF;
        drive(10'h2AA, 4'd15, 24'hFFFFFF, 3'd7);
        tick();
        upd_vld = 1'b0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            check("t3_stall_early", d1_stall, 0);
            tick();
        end
        check("t3_stall_ninth", d1_stall, 1);
        check("t3_we_before",   ram_we,   0);
        tick();
        check("t3_we",          ram_we,       1);
        check("t3_set",         ram_set,      32'h2AA);
        check("t3_mask",        ram_way_mask, 32'h8000);
        check("t3_wdata",       ram_wdata,    32'h7FFFFFF);
        check("t3_stall_off",   d1_stall,     0);
        check("t3_q_cnt",       q_cnt,        0);
        drive(10'h2AB, 4'd0, 24'h0, 3'd0);
        tick();
        upd_vld = 1'b0;
        #1;
        check("t3_cnt_cleared", d1_stall, 0);
        d1_rd_req = 1'b0;
        tick();
        check("t3_second_we",   ram_we,  1);
        check("t3_second_set",  ram_set, 32'h2AB);
        tick();

        // Hazard against queued and in-flight writes
        d1_rd_req = 1'b1;
        d1_rd_set = 10'h40;
        drive(10'h40, 4'd3, 24'h000040, 3'd2);
        #1;
        check("t4_push_invisible", d1_haz, 0);
        tick();
        upd_vld = 1'b0;
        #1;
        check("t4_haz_queued", d1_haz, 1);
        d1_rd_set = 10'h41;
        #1;
        check("t4_haz_other",  d1_haz, 0);
        d1_rd_req = 1'b0;
        d1_rd_set = 10'h40;
        #1;
        check("t4_haz_no_req", d1_haz, 0);
        tick();
        d1_rd_req = 1'b1;
        #1;
        check("t4_we_0x40",    ram_we, 1);
        check("t4_haz_inflight", d1_haz, 1);
        d1_rd_set = 10'h41;
        #1;
        check("t4_haz_inflight_other", d1_haz, 0);
        d1_rd_req = 1'b0;
        tick();

        // Ordering of two writes to the same set/way
        drive(10'h7, 4'd2, 24'h1, 3'd0);
        tick();
        drive(10'h7, 4'd2, 24'h2, 3'd0);
        tick();
        upd_vld = 1'b0;
        #1;
        check("t5_we_first",    ram_we,       1);
        check("t5_set",         ram_set,      32'h7);
        check("t5_mask",        ram_way_mask, 32'h0004);
        check("t5_wdata_first", ram_wdata,    32'h8);
        tick();
        check("t5_we_second",    ram_we,    1);
        check("t5_wdata_second", ram_wdata, 32'h10);
        check("t5_q_cnt",        q_cnt,     0);
        tick();
        check("t5_we_done",      ram_we,    0);

        // Reset mid-operation discards queued and registered writes
        d1_rd_req = 1'b1;
        d1_rd_set = 10'h3FF;
        for (int i = 0; i < 3; i++) begin
            drive(10'h300 + 10'(i), 4'(i), 24'h300 + 24'(i), 3'd1);
            tick();
        end
        upd_vld = 1'b0;
        #1;
        check("t6_q_cnt_3", q_cnt, 3);
        d1_rd_req = 1'b0;
        tick();
        check("t6_we_pre",  ram_we,  1);
        check("t6_set_pre", ram_set, 32'h300);
        check("t6_cnt_pre", q_cnt,   2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6_q_cnt_0",   q_cnt,   0);
        check("t6_ram_we_0",  ram_we,  0);
        check("t6_upd_rdy",   upd_rdy, 1);
        check("t6_ram_set_0", ram_set, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_no_stale_we", ram_we, 0);
            check("t6_cnt_stays_0", q_cnt,  0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
